// File: rtl/board_io_scanner.sv
// Seven-segment scanner with button debounce and switch sync.
// Display pins are registered one clock after the scan state.
module board_io_scanner #(
  parameter int n_digits        = 4,
  parameter int n_buttons       = 4,
  parameter int n_switches      = 8,
  parameter int digit_period    = 50000,
  parameter int blank_cycles    = 16,
  parameter int debounce_cycles = 500000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*n_digits-1:0]   digits,
  input  logic [n_digits-1:0]     dots,
  input  logic [n_digits-1:0]     digit_enable,
  input  logic [n_buttons-1:0]    buttons,
  input  logic [n_switches-1:0]   switches,
  output logic [n_buttons-1:0]    buttons_level,
  output logic [n_buttons-1:0]    buttons_pressed,
  output logic [n_switches-1:0]   switches_sync,
  output logic [6:0]              seven_segments,
  output logic                    dot,
  output logic [n_digits-1:0]     anodes
);

  localparam int cw = (digit_period > 1) ? $clog2(digit_period) : 1;
  localparam int iw = (n_digits > 1) ? $clog2(n_digits) : 1;
  localparam int dw = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;

  localparam logic [cw-1:0] slot_last = cw'(digit_period - 1);
  localparam logic [cw-1:0] blank_end = cw'(blank_cycles);
  localparam logic [iw-1:0] idx_last  = iw'(n_digits - 1);
  localparam logic [dw-1:0] deb_last  = dw'(debounce_cycles - 1);
  localparam logic [n_digits-1:0] an_one = n_digits'(1);

  logic [cw-1:0] slot;
  logic [iw-1:0] idx;
  logic [3:0]    nib;
  logic          dp_sel;
  logic          en_sel;

  logic [n_buttons-1:0]  b_meta;
  logic [n_buttons-1:0]  b_sync;
  logic [dw-1:0]         dcnt [n_buttons];
  logic [n_switches-1:0] sw_meta;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      4'hf: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // slot counter and digit index advancing on each slot wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot == slot_last) begin
      slot <= '0;
      idx  <= (idx == idx_last) ? '0 : idx + 1'b1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // pick the nibble, dot and enable of the current digit
  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    en_sel = 1'b0;
    for (int i = 0; i < n_digits; i++) begin
      if (idx == iw'(i)) begin
        nib    = digits[4*i +: 4];
        dp_sel = dots[i];
        en_sel = digit_enable[i];
      end
    end
  end

  // registered display pins, live data, blanking on disabled digits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anodes         <= '1;
      seven_segments <= 7'h7f;
      dot            <= 1'b1;
    end else if (!en_sel) begin
      anodes         <= '1;
      seven_segments <= 7'h7f;
      dot            <= 1'b1;
    end else begin
      seven_segments <= seg_decode(nib);
      dot            <= ~dp_sel;
      anodes         <= (slot < blank_end) ? '1 : ~(an_one << idx);
    end
  end

  // button sync and per-button debounce with rising-edge pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_meta          <= '0;
      b_sync          <= '0;
      buttons_level   <= '0;
      buttons_pressed <= '0;
      for (int i = 0; i < n_buttons; i++) dcnt[i] <= '0;
    end else begin
      b_meta          <= buttons;
      b_sync          <= b_meta;
      buttons_pressed <= '0;
      for (int i = 0; i < n_buttons; i++) begin
        if (b_sync[i] == buttons_level[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == deb_last) begin
          buttons_level[i]   <= b_sync[i];
          buttons_pressed[i] <= b_sync[i];
          dcnt[i]            <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // two-flop switch synchroniser
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta       <= '0;
      switches_sync <= '0;
    end else begin
      sw_meta       <= switches;
      switches_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_board_io_scanner.sv
// Bench for board_io_scanner: reference model on edge counts.
// Display and debounce expectations derived from elapsed clocks.
module tb_board_io_scanner;

  localparam int ND = 4;
  localparam int NB = 4;
  localparam int NS = 8;
  localparam int P  = 4;
  localparam int B  = 1;
  localparam int D  = 3;
  localparam int HN = 8192;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dots = '0;
  logic [3:0]    digit_enable = '0;
  logic [3:0]    buttons = '0;
  logic [7:0]    switches = '0;
  logic [3:0]    buttons_level;
  logic [3:0]    buttons_pressed;
  logic [7:0]    switches_sync;
  logic [6:0]    seven_segments;
  logic          dot;
  logic [3:0]    anodes;

  int tests = 0;
  int fails = 0;

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  board_io_scanner #(
    .n_digits(ND), .n_buttons(NB), .n_switches(NS),
    .digit_period(P), .blank_cycles(B), .debounce_cycles(D)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .digits(digits), .dots(dots), .digit_enable(digit_enable),
    .buttons(buttons), .switches(switches),
    .buttons_level(buttons_level),
    .buttons_pressed(buttons_pressed),
    .switches_sync(switches_sync),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes)
  );

  always #5 clock = ~clock;

  // model state: edges since release and raw input history
  int         m_e;
  logic [3:0] hist [HN];
  logic [7:0] swh [HN];
  logic [3:0] m_level;
  logic [3:0] m_pressed;
  int         last_flip [NB];

  function automatic logic synced(int x, int i);
    if (x < 2) return 1'b0;
    return hist[(x - 2) % HN][i];
  endfunction

  // a button flips once its synced value has differed
  // for D consecutive edges, all after the previous flip
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_e = 0;
      m_level = '0;
      m_pressed = '0;
      for (int i = 0; i < NB; i++) last_flip[i] = -D;
    end else begin
      hist[m_e % HN] = buttons;
      swh[m_e % HN] = switches;
      m_pressed = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_e - last_flip[i] >= D) begin
          automatic bit ok = 1'b1;
          for (int j = 0; j < D; j++)
            if (synced(m_e - j, i) == m_level[i]) ok = 1'b0;
          if (ok) begin
            m_level[i] = ~m_level[i];
            m_pressed[i] = m_level[i];
            last_flip[i] = m_e;
          end
        end
      end
      m_e = m_e + 1;
    end
  end

  function automatic logic [7:0] exp_sw(int n);
    if (n < 2) return 8'h00;
    return swh[(n - 2) % HN];
  endfunction

  // expected {anodes, segments, dot} after n edges
  function automatic logic [11:0] exp_disp(int n);
    int k, pos, idx;
    logic [3:0] an;
    logic [3:0] nb;
    if (n == 0) return 12'hfff;
    k = n - 1;
    pos = k % P;
    idx = (k / P) % ND;
    if (!digit_enable[idx]) return 12'hfff;
    an = (pos < B) ? 4'hf : ~(4'b0001 << idx);
    nb = digits[idx*4 +: 4];
    return {an, segtab[nb], ~dots[idx]};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    buttons = 4'hf;
    switches = 8'hff;
    digit_enable = 4'hf;
    repeat (3) @(negedge clock);
    tests++;
    if ({anodes, seven_segments, dot} !== 12'hfff) begin
      fails++;
      $display("FAIL reset_disp got %h want fff",
               {anodes, seven_segments, dot});
    end
    tests++;
    if ({buttons_level, buttons_pressed} !== 8'h00) begin
      fails++;
      $display("FAIL reset_btn got %h want 00",
               {buttons_level, buttons_pressed});
    end
    tests++;
    if (switches_sync !== 8'h00) begin
      fails++;
      $display("FAIL reset_sw got %h want 00", switches_sync);
    end
    buttons = '0;
    switches = '0;
  endtask

  task automatic test_scan();
    digits = 16'h1234;
    dots = 4'h0;
    digit_enable = 4'hf;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      tests++;
      if ({anodes, seven_segments, dot} !== exp_disp(m_e)) begin
        fails++;
        $display("FAIL scan c=%0d got %b want %b", c,
                 {anodes, seven_segments, dot}, exp_disp(m_e));
      end
      if (c == 2) begin
        tests++;
        if ({anodes, seven_segments} !== {4'b1110, 7'b0011001}) begin
          fails++;
          $display("FAIL scan_d0 got %b %b want 1110 0011001",
                   anodes, seven_segments);
        end
      end
      if (c == 6) begin
        tests++;
        if ({anodes, seven_segments} !== {4'b1101, 7'b0110000}) begin
          fails++;
          $display("FAIL scan_d1 got %b %b want 1101 0110000",
                   anodes, seven_segments);
        end
      end
      if (c == 18) begin
        tests++;
        if (anodes !== 4'b1110) begin
          fails++;
          $display("FAIL scan_wrap got %b want 1110", anodes);
        end
      end
    end
  endtask

  task automatic test_blank_dot();
    digit_enable = 4'b1011;
    dots = 4'b0001;
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      tests++;
      if ({anodes, seven_segments, dot} !== exp_disp(m_e)) begin
        fails++;
        $display("FAIL blank c=%0d got %b want %b", c,
                 {anodes, seven_segments, dot}, exp_disp(m_e));
      end
      if (c >= 9 && c <= 12) begin
        tests++;
        if ({anodes, seven_segments, dot} !== 12'hfff) begin
          fails++;
          $display("FAIL blank_d2 got %b want all ones",
                   {anodes, seven_segments, dot});
        end
      end
      if (c == 3) begin
        tests++;
        if (dot !== 1'b0) begin
          fails++;
          $display("FAIL dot_d0 got %b want 0", dot);
        end
      end
    end
  endtask

  task automatic test_live_update();
    digits = 16'h0000;
    dots = 4'h0;
    digit_enable = 4'hf;
    do_reset();
    repeat (2) @(negedge clock);
    digits = 16'h000e;
    @(negedge clock);
    tests++;
    if (seven_segments !== 7'b0000110) begin
      fails++;
      $display("FAIL live got %b want 0000110", seven_segments);
    end
  endtask

  task automatic test_random_display();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      tests++;
      if ({anodes, seven_segments, dot} !== exp_disp(m_e)) begin
        fails++;
        $display("FAIL rand_disp c=%0d got %b want %b", c,
                 {anodes, seven_segments, dot}, exp_disp(m_e));
      end
      if (hold == 0) begin
        digits = 16'($urandom);
        dots = 4'($urandom);
        digit_enable = 4'($urandom);
        hold = $urandom_range(1, 6);
      end
      hold--;
    end
  endtask

  task automatic test_debounce();
    digit_enable = 4'hf;
    buttons = '0;
    do_reset();
    repeat (6) @(negedge clock);
    buttons = 4'b0001;
    repeat (2) @(negedge clock);
    buttons = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      tests++;
      if ({buttons_level, buttons_pressed} !== 8'h00) begin
        fails++;
        $display("FAIL bounce got %b %b want 0000 0000",
                 buttons_level, buttons_pressed);
      end
    end
    buttons = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      tests++;
      if (buttons_level[0] !== (c >= 5) ||
          buttons_pressed[0] !== (c == 5)) begin
        fails++;
        $display("FAIL press c=%0d got lvl=%b prs=%b want %b %b", c,
                 buttons_level[0], buttons_pressed[0], c >= 5, c == 5);
      end
    end
    buttons = 4'b0000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      tests++;
      if (buttons_level[0] !== (c < 5) || buttons_pressed !== 4'b0) begin
        fails++;
        $display("FAIL release c=%0d got lvl=%b prs=%b want %b 0000", c,
                 buttons_level[0], buttons_pressed, c < 5);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    buttons = 4'b0000;
    repeat (8) @(negedge clock);
    buttons = 4'b1001;
    while (buttons_pressed == 4'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (buttons_pressed !== 4'b1001 || buttons_level !== 4'b1001) begin
      fails++;
      $display("FAIL simul after %0d got prs=%b lvl=%b want 1001 1001",
               n, buttons_pressed, buttons_level);
    end
    @(negedge clock);
    tests++;
    if (buttons_pressed !== 4'b0000) begin
      fails++;
      $display("FAIL simul_once got %b want 0000", buttons_pressed);
    end
    buttons = 4'b0000;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_switches();
    switches = 8'h3c;
    repeat (4) @(negedge clock);
    switches = 8'ha5;
    @(negedge clock);
    tests++;
    if (switches_sync !== 8'h3c) begin
      fails++;
      $display("FAIL sw_1clk got %h want 3c", switches_sync);
    end
    @(negedge clock);
    tests++;
    if (switches_sync !== 8'ha5) begin
      fails++;
      $display("FAIL sw_2clk got %h want a5", switches_sync);
    end
  endtask

  task automatic test_random_buttons();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      tests++;
      if ({buttons_level, buttons_pressed} !== {m_level, m_pressed}) begin
        fails++;
        $display("FAIL rand_btn c=%0d got %b %b want %b %b", c,
                 buttons_level, buttons_pressed, m_level, m_pressed);
      end
      tests++;
      if (switches_sync !== exp_sw(m_e)) begin
        fails++;
        $display("FAIL rand_sw c=%0d got %h want %h", c,
                 switches_sync, exp_sw(m_e));
      end
      if (hold == 0) begin
        buttons = 4'($urandom);
        hold = $urandom_range(1, 6);
      end
      switches = 8'($urandom);
      hold--;
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    digits = 16'h1234;
    dots = 4'hf;
    digit_enable = 4'hf;
    buttons = '0;
    switches = 8'hff;
    do_reset();
    repeat (8) @(negedge clock);
    buttons = 4'b0010;
    repeat (3) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({anodes, seven_segments, dot} !== 12'hfff ||
        {buttons_level, buttons_pressed, switches_sync} !== 16'h0000) begin
      fails++;
      $display("FAIL async_rst got %b %h want fff 0000",
               {anodes, seven_segments, dot},
               {buttons_level, buttons_pressed, switches_sync});
    end
    buttons = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      tests++;
      if ({anodes, seven_segments, dot} !== exp_disp(m_e) ||
          buttons_pressed !== 4'b0) begin
        fails++;
        $display("FAIL post_rst c=%0d got %b %b want %b 0000", c,
                 {anodes, seven_segments, dot}, buttons_pressed,
                 exp_disp(m_e));
      end
      if (!seen && anodes !== 4'hf) begin
        seen = 1'b1;
        tests++;
        if (anodes !== 4'b1110 || c != 2) begin
          fails++;
          $display("FAIL first_digit c=%0d got %b want 1110 at 2",
                   c, anodes);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_dot();
    test_live_update();
    test_random_display();
    test_debounce();
    test_simultaneous();
    test_switches();
    test_random_buttons();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/board_io_scanner.md
BOARD_IO_SCANNER -- requirements
Module: board_io_scanner

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- n_digits, 4, number of seven-segment digits scanned; legal range 1..8.
- n_buttons, 4, number of push buttons debounced.
- n_switches, 8, number of slide switches synchronised.
- digit_period, 50000, clocks per digit slot; minimum 2.
- blank_cycles, 16, clocks at the start of each slot with all anodes off; must be less than digit_period.
- debounce_cycles, 500000, clocks a button change must persist before it is accepted; minimum 1.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clock, in, 1, single clock for the whole block.
- reset_n, in, 1, asynchronous active-low reset.
- digits, in, 4*n_digits, hex nibble per digit; digit i is [4i+3:4i].
- dots, in, n_digits, decimal point request per digit, active high.
- digit_enable, in, n_digits, per-digit enable; 0 blanks that digit.
- buttons, in, n_buttons, raw asynchronous buttons, active high.
- switches, in, n_switches, raw asynchronous switches.
- buttons_level, out, n_buttons, debounced button state.
- buttons_pressed, out, n_buttons, one-cycle pulse on a debounced 0->1 transition.
- switches_sync, out, n_switches, synchronised switches.
- seven_segments, out, 7, segments {g,f,e,d,c,b,a}, active low.
- dot, out, 1, decimal point, active low.
- anodes, out, n_digits, digit select, active low.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-low reset named reset_n.

Function
REQ-004 The slot counter SHALL count 0..digit_period-1 and wrap to 0.
REQ-005 On each wrap, the digit index SHALL advance by 1 modulo n_digits (n_digits-1 -> 0).
REQ-006 Anodes SHALL be all 1 while slot count < blank_cycles.
REQ-007 Otherwise, anodes[idx] SHALL be 0 and all other bits 1, or all bits 1 if digit_enable[idx]=0.
REQ-008 seven_segments SHALL be the registered decode of nibble idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-009 dot SHALL equal ~dots[idx]. When a digit is blanked, seven_segments SHALL be 1111111 and dot SHALL be 1.
REQ-010 All display outputs SHALL be registered, with exactly 1 clock of latency from the count/index state to the pins.
REQ-011 Changes on digits, dots or digit_enable SHALL appear on the pins 1 clock later, without waiting for the slot to end.
REQ-012 Each button SHALL pass through a 2-flop synchroniser, then a per-button debouncer as follows:
- The counter clears whenever the synchronised value equals buttons_level.
- Otherwise the counter increments.
- On reaching debounce_cycles-1 while still different, buttons_level takes the new value and the counter clears.
REQ-013 A bounce shorter than debounce_cycles SHALL leave buttons_level unchanged.
REQ-014 buttons_pressed[i] SHALL be 1 for exactly the cycle after buttons_level[i] rises, and SHALL never pulse on a fall.
REQ-015 Simultaneous presses on several buttons SHALL be handled independently, with no priority between them.
REQ-016 switches_sync SHALL be a 2-flop synchronised copy of switches, giving 2 clocks of latency and no debounce.
REQ-017 Counter widths SHALL be the minimum clog2 width of their terminal values; counters SHALL NOT overflow at parameter maxima.

Reset
REQ-018 While reset_n=0, the following SHALL hold:
- anodes all 1, seven_segments 1111111, dot 1.
- buttons_level 0, buttons_pressed 0, switches_sync 0.
- Slot counter, digit index, debounce counters and synchroniser flops all 0.
REQ-019 Reset assertion SHALL take effect immediately, independent of clock, including mid-slot or mid-debounce. Release SHALL be synchronous to clock.
REQ-020 After release, scanning SHALL restart at digit 0, slot count 0, with a blank phase first.

Verification (n_digits=4, digit_period=4, blank_cycles=1, debounce_cycles=3)
REQ-021 Scan: digits=16'h1234, dots=0, enable=1111. Expect per 4-clock slot:
- 1 clock anodes=1111, then 3 clocks anodes=1110 with segments=0011001 (digit 0 = 4).
- Then digit 1 with anodes=1101 and segments=0110000, and so on.
- Wrap from 0111 back to 1110.
REQ-022 Blanking and dot: enable=1011, dots=0001. Expect:
- Digit 2 slot: anodes=1111, segments=1111111, dot=1.
- Digit 0 slot: dot=0.
REQ-023 Debounce: hold button[0] high 2 clocks, then low. Expect buttons_level=0 and no pulse. Then hold it high 10 clocks. Expect:
- buttons_level[0]=1 at 2+3 clocks after the edge.
- A single-cycle buttons_pressed[0].
- Release produces no pulse.
REQ-024 Simultaneous: buttons 0 and 3 rise together. Expect both pulses in the same cycle and buttons_pressed=1001.
REQ-025 Reset mid-operation: assert reset_n=0 in digit 2, mid-debounce. Expect:
- All outputs at reset values without a clock edge.
- After release, digit 0 first and no spurious pulse.
REQ-026 Switches: toggle switches to 8'hA5. Expect switches_sync=8'hA5 exactly 2 clocks later.
